// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// digit geometry, correction constants, FSM state type and a helper
// that sizes the binary result for a given digit count.
package bcd_pkg;

   localparam int unsigned            DIGIT_W    = 4;
   localparam logic [DIGIT_W-1:0]     DIGIT_MAX  = 4'd9;
   localparam logic [DIGIT_W-1:0]     ADJ_THRESH = 4'd8;
   localparam logic [DIGIT_W-1:0]     ADJ_SUB    = 4'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Smallest width w with 2^w >= 10^n_digits.
   function automatic int unsigned min_bin_w(input int unsigned n_digits);
      longint unsigned span;
      int unsigned     w;
      span = 64'd1;
      w    = 0;
      for (int unsigned i = 0; i < n_digits; i++)
         span = span * (64'(DIGIT_MAX) + 64'd1);
      for (int unsigned b = 0; b < 64; b++)
         if ((64'd1 << b) < span) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: a digit that picked up
// a half-weight bit (value >= 8) after the right shift is pulled back by 3.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   // Correction never underflows because it only applies at >= 8.
   assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_SUB) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one shift/correct step per clock.
// Optional build macro BCD_TO_BIN_CHECK_EN: reject operands containing a
// digit above 9 at acceptance (err=1, bin_out=0, done on the next cycle).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operand captured on the accepting edge
// SHIFT | one shift-right + digit correction per cycle, BIN_W cycles
// DONE  | done pulse for one cycle, start ignored, then back to IDLE
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int unsigned N_DIGITS = 2,
   parameter int unsigned BIN_W    = min_bin_w(N_DIGITS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [DIGIT_W*N_DIGITS-1:0] bcd_in,
   output logic                        busy,
   output logic                        done,
   output logic [BIN_W-1:0]            bin_out,
   output logic                        err
);

   localparam int unsigned BCD_W    = DIGIT_W * N_DIGITS;
   localparam int unsigned CNT_W    = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t             state_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [BIN_W-1:0]   bin_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [BIN_W-1:0]   bin_out_q;

   logic [BCD_W+BIN_W-1:0] shifted;
   logic [BCD_W-1:0]       bcd_shift;
   logic [BCD_W-1:0]       bcd_d;
   logic [BIN_W-1:0]       bin_d;

   // The bcd LSB falls into the binary MSB on every shift.
   assign shifted   = {bcd_q, bin_q} >> 1;
   assign bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];
   assign bin_d     = shifted[BIN_W-1:0];

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (bcd_shift[g*DIGIT_W +: DIGIT_W]),
         .digit_o (bcd_d[g*DIGIT_W +: DIGIT_W])
      );
   end

`ifdef BCD_TO_BIN_CHECK_EN
   logic err_q;
   logic bad_digit;

   // Flags any operand digit outside 0..9 at the input pins.
   always_comb begin
      bad_digit = 1'b0;
      for (int unsigned i = 0; i < N_DIGITS; i++)
         if (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) bad_digit = 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Control FSM, iteration counter, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bin_out_q <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  bcd_q   <= bcd_in;
                  bin_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
`ifdef BCD_TO_BIN_CHECK_EN
                  // Rejected operands skip the shift phase entirely.
                  if (bad_digit) begin
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     bin_out_q <= '0;
                     err_q     <= 1'b1;
                     state_q   <= DONE;
                  end
`endif
               end
            end
            SHIFT: begin
               bcd_q <= bcd_d;
               bin_q <= bin_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  bin_out_q <= bin_d;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
`ifdef BCD_TO_BIN_CHECK_EN
                  err_q     <= 1'b0;
`endif
                  state_q   <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: a cycle-level handshake model pushes
// expected results on every accepted start; a monitor pops on each done.
module tb_bcd_to_bin_seq;

   localparam int BIN_W = 7;

   typedef struct {
      logic [7:0] bcd;
      int         exp_bin;
      logic       exp_err;
      bit         bin_known;
      int         done_cyc;
   } exp_t;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic [7:0] bcd_in = '0;
   logic       busy, done, err;
   logic [BIN_W-1:0] bin_out;

   logic        start3 = 1'b0;
   logic [11:0] bcd3   = '0;
   logic        busy3, done3, err3;
   logic [9:0]  bin3;

   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   next_acc = 0;
   int   last_acc = 0;
   bit   have_acc = 1'b0;
   bit   last_rej = 1'b0;
   int   hold_bin = 0;
   int   hold_err = 0;
   bit   hold_known = 1'b1;
   exp_t sb[$];
   exp_t m_e;
   exp_t mon_e;

   bcd_to_bin_seq #(.N_DIGITS(2), .BIN_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
      .busy(busy), .done(done), .bin_out(bin_out), .err(err)
   );

   bcd_to_bin_seq #(.N_DIGITS(3), .BIN_W(10)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
      .busy(busy3), .done(done3), .bin_out(bin3), .err(err3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit bcd_ok(input logic [7:0] b);
      return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
   endfunction

   function automatic int bcd_value(input logic [7:0] b);
      return 10 * int'(b[7:4]) + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] rand_bcd(input bit valid);
      logic [7:0] b;
      b[3:0] = 4'($urandom_range(0, 9));
      b[7:4] = 4'($urandom_range(0, 9));
      if (!valid) begin
         if ($urandom_range(0, 1) == 0) b[3:0] = 4'($urandom_range(10, 15));
         else                           b[7:4] = 4'($urandom_range(10, 15));
      end
      return b;
   endfunction

   // Handshake model: an edge with start high is accepted once the previous
   // conversion has fully drained (done cycle plus the return to idle).
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && start && cyc >= next_acc) begin
         m_e.bcd = bcd_in;
         if (bcd_ok(bcd_in)) begin
            m_e.exp_bin   = bcd_value(bcd_in);
            m_e.exp_err   = 1'b0;
            m_e.bin_known = 1'b1;
            m_e.done_cyc  = cyc + BIN_W;
            last_rej      = 1'b0;
         end else begin
`ifdef BCD_TO_BIN_CHECK_EN
            m_e.exp_bin   = 0;
            m_e.exp_err   = 1'b1;
            m_e.bin_known = 1'b1;
            m_e.done_cyc  = cyc;
            last_rej      = 1'b1;
`else
            m_e.exp_bin   = 0;
            m_e.exp_err   = 1'b0;
            m_e.bin_known = 1'b0;
            m_e.done_cyc  = cyc + BIN_W;
            last_rej      = 1'b0;
`endif
         end
         next_acc = m_e.done_cyc + 2;
         last_acc = cyc;
         have_acc = 1'b1;
         sb.push_back(m_e);
      end
   end

   always @(negedge rst_n) begin
      sb.delete();
      have_acc   = 1'b0;
      last_rej   = 1'b0;
      next_acc   = 0;
      hold_bin   = 0;
      hold_err   = 0;
      hold_known = 1'b1;
   end

   // Monitor: compares every done against the scoreboard, and checks busy
   // and the held result on every other cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!done && sb.size() > 0 && cyc >= sb[0].done_cyc) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: no done by cycle %0d for bcd 0x%02h", cyc, sb[0].bcd);
            void'(sb.pop_front());
         end
         if (done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL spurious_done: done high at cycle %0d, expected none", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("done_cycle", cyc, mon_e.done_cyc);
               chk("err", int'(err), int'(mon_e.exp_err));
               if (mon_e.bin_known) chk("bin_out", int'(bin_out), mon_e.exp_bin);
               hold_bin   = mon_e.exp_bin;
               hold_err   = int'(mon_e.exp_err);
               hold_known = mon_e.bin_known;
            end
         end else begin
            if (hold_known) chk("bin_hold", int'(bin_out), hold_bin);
            chk("err_hold", int'(err), hold_err);
         end
         chk("busy", int'(busy),
             int'(have_acc && !last_rej && cyc >= last_acc && cyc < last_acc + BIN_W));
      end
   end

   task automatic step(input logic s, input logic [7:0] b);
      @(negedge clk);
      start  = s;
      bcd_in = b;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'($urandom));
   endtask

   task automatic run3(input logic [11:0] b, input int exp);
      int lat;
      repeat (2) @(negedge clk);
      start3 = 1'b1;
      bcd3   = b;
      @(negedge clk);
      start3 = 1'b0;
      bcd3   = 12'($urandom);
      lat    = 0;
      while (!done3 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("lat3", lat, 10);
      chk("bin3", int'(bin3), exp);
      chk("err3", int'(err3), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bin", int'(bin_out), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_bin3", int'(bin3), 0);
      chk("rst_busy3", int'(busy3), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      step(1'b1, 8'h42); idle(11);
      step(1'b1, 8'h00); idle(11);
      step(1'b1, 8'h99); idle(11);

      // Starts during SHIFT cycles 2 and 5 and during the done cycle.
      step(1'b1, 8'h64);
      step(1'b0, 8'h00);
      step(1'b1, 8'h11);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      step(1'b1, 8'h22);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      step(1'b1, 8'h33);
      idle(11);

      // Start held high while the operand changes every cycle.
      for (int i = 0; i < 40; i++) step(1'b1, rand_bcd(1'b1));
      idle(12);

      // Asynchronous reset in the third SHIFT cycle of 0x57.
      step(1'b1, 8'h57);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("amid_busy", int'(busy), 0);
      chk("amid_done", int'(done), 0);
      chk("amid_bin", int'(bin_out), 0);
      chk("amid_err", int'(err), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      step(1'b1, 8'h13); idle(11);

      // Random operands (some invalid) with random gaps and stray starts.
      for (int i = 0; i < 30; i++) begin
         step(1'b1, rand_bcd($urandom_range(0, 7) != 0));
         for (int j = 0; j < int'($urandom_range(0, 12)); j++)
            step($urandom_range(0, 3) == 0, rand_bcd(1'b1));
      end
      idle(12);

      step(1'b1, 8'h1A); idle(11);
      step(1'b1, 8'hF9); idle(11);

      run3(12'h999, 999);
      run3(12'h000, 0);
      run3(12'h507, 507);
      for (int i = 0; i < 4; i++) begin
         v = int'($urandom_range(0, 999));
         run3(12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10)), v);
      end

      idle(15);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
